// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and constants for the writeback round-robin arbiter.
// The optional BLIMP_WB_ARB_STATS_EN macro enables the per-pipe grant counters.
package wb_rr_arbiter_pkg;

  localparam int unsigned WB_SEQ_W  = 5;
  localparam int unsigned WB_PC_W   = 32;
  localparam int unsigned WB_ADDR_W = 5;
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned CNT_W     = 16;

  localparam logic [CNT_W-1:0] SATURATE = 16'hFFFF;

  // One writeback message at the default sequence-number width.
  typedef struct packed {
    logic [WB_SEQ_W-1:0]  seq_num;
    logic [WB_PC_W-1:0]   pc;
    logic [WB_ADDR_W-1:0] waddr;
    logic [WB_DATA_W-1:0] wdata;
    logic                 wen;
  } wb_msg_t;

  // Width of a pipe index; a single pipe still needs one bit.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Request-side and output-side channels of the writeback arbiter.
// master: the arbiter itself (drives req_rdy and the buffered output).
// slave:  the surrounding pipes and the downstream consumer.
interface wb_rr_arbiter_if
  import wb_rr_arbiter_pkg::*;
#(
  parameter int unsigned p_num_pipes    = 2,
  parameter int unsigned p_seq_num_bits = WB_SEQ_W
);

  localparam int unsigned PTR_W = ptr_w(p_num_pipes);

  logic [p_num_pipes-1:0]                      req_val;
  logic [p_num_pipes-1:0]                      req_rdy;
  logic [p_num_pipes-1:0][p_seq_num_bits-1:0]  req_seq_num;
  logic [p_num_pipes-1:0][WB_PC_W-1:0]         req_pc;
  logic [p_num_pipes-1:0][WB_ADDR_W-1:0]       req_waddr;
  logic [p_num_pipes-1:0][WB_DATA_W-1:0]       req_wdata;
  logic [p_num_pipes-1:0]                      req_wen;

  logic                      out_val;
  logic                      out_rdy;
  logic [p_seq_num_bits-1:0] out_seq_num;
  logic [WB_PC_W-1:0]        out_pc;
  logic [WB_ADDR_W-1:0]      out_waddr;
  logic [WB_DATA_W-1:0]      out_wdata;
  logic                      out_wen;
  logic [PTR_W-1:0]          out_src;

  modport master (
    input  req_val, req_seq_num, req_pc, req_waddr, req_wdata, req_wen, out_rdy,
    output req_rdy, out_val, out_seq_num, out_pc, out_waddr, out_wdata, out_wen, out_src
  );

  modport slave (
    output req_val, req_seq_num, req_pc, req_waddr, req_wdata, req_wen, out_rdy,
    input  req_rdy, out_val, out_seq_num, out_pc, out_waddr, out_wdata, out_wen, out_src
  );

endinterface

// File: rtl/wb_rr_arbiter_rr_grant_picker.sv
// Combinational rotating-priority picker: first valid request scanning
// cyclically from the priority pointer.
module rr_grant_picker
  import wb_rr_arbiter_pkg::*;
#(
  parameter int unsigned p_num_pipes = 2
) (
  input  logic [p_num_pipes-1:0]        i_req_val,
  input  logic [ptr_w(p_num_pipes)-1:0] i_ptr,
  output logic [p_num_pipes-1:0]        o_grant_c,
  output logic [ptr_w(p_num_pipes)-1:0] o_grant_idx_c,
  output logic                          o_any_grant_c
);

  localparam int unsigned PTR_W = ptr_w(p_num_pipes);

  int unsigned w_idx;

  // Scan ptr, ptr+1, ... modulo p_num_pipes; the first valid pipe wins.
  always_comb begin
    o_grant_c     = '0;
    o_grant_idx_c = '0;
    o_any_grant_c = 1'b0;
    w_idx         = 0;
    for (int unsigned k = 0; k < p_num_pipes; k++) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= p_num_pipes) w_idx = w_idx - p_num_pipes;
      if (!o_any_grant_c && i_req_val[PTR_W'(w_idx)]) begin
        o_grant_c[PTR_W'(w_idx)] = 1'b1;
        o_grant_idx_c            = PTR_W'(w_idx);
        o_any_grant_c            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing the writeback channel among execute pipes,
// with a one-entry registered output buffer and val/rdy handshakes.
// Optional feature macro: BLIMP_WB_ARB_STATS_EN adds saturating per-pipe
// grant counters on the grant_count port.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int unsigned p_num_pipes    = 2,
  parameter int unsigned p_seq_num_bits = WB_SEQ_W
) (
  input  logic clk,
  input  logic rst,
  wb_rr_arbiter_if.master bus
`ifdef BLIMP_WB_ARB_STATS_EN
  ,
  output logic [p_num_pipes-1:0][CNT_W-1:0] grant_count
`endif
);

  localparam int unsigned PTR_W = ptr_w(p_num_pipes);

  typedef struct packed {
    logic [p_seq_num_bits-1:0] seq_num;
    logic [WB_PC_W-1:0]        pc;
    logic [WB_ADDR_W-1:0]      waddr;
    logic [WB_DATA_W-1:0]      wdata;
    logic                      wen;
  } msg_t;

  logic             r_out_val;
  msg_t             r_msg;
  logic [PTR_W-1:0] r_src;
  logic [PTR_W-1:0] r_ptr;

  logic [p_num_pipes-1:0] w_grant;
  logic [PTR_W-1:0]       w_grant_idx;
  logic                   w_any_grant;
  logic                   w_can_accept;
  logic                   w_xfer;
  logic [PTR_W-1:0]       w_ptr_next;
  msg_t                   w_msg_sel;

  rr_grant_picker #(
    .p_num_pipes (p_num_pipes)
  ) u_picker (
    .i_req_val     (bus.req_val),
    .i_ptr         (r_ptr),
    .o_grant_c     (w_grant),
    .o_grant_idx_c (w_grant_idx),
    .o_any_grant_c (w_any_grant)
  );

  // Accept a new message when the buffer is empty or draining this cycle.
  assign w_can_accept = !r_out_val || bus.out_rdy;
  assign w_xfer       = w_any_grant && w_can_accept;
  assign bus.req_rdy  = w_grant & {p_num_pipes{w_can_accept}};

  // Pointer advances past the winner; explicit wrap handles non-power-of-2 counts.
  assign w_ptr_next = (w_grant_idx == PTR_W'(p_num_pipes - 1)) ? '0
                                                               : w_grant_idx + PTR_W'(1);

  // Payload of the granted pipe.
  always_comb begin
    w_msg_sel         = '0;
    w_msg_sel.seq_num = bus.req_seq_num[w_grant_idx];
    w_msg_sel.pc      = bus.req_pc[w_grant_idx];
    w_msg_sel.waddr   = bus.req_waddr[w_grant_idx];
    w_msg_sel.wdata   = bus.req_wdata[w_grant_idx];
    w_msg_sel.wen     = bus.req_wen[w_grant_idx];
  end

  // Output buffer and priority pointer; a drain without a new grant only clears valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_val <= 1'b0;
      r_msg     <= '0;
      r_src     <= '0;
      r_ptr     <= '0;
    end else if (w_xfer) begin
      r_out_val <= 1'b1;
      r_msg     <= w_msg_sel;
      r_src     <= w_grant_idx;
      r_ptr     <= w_ptr_next;
    end else if (bus.out_rdy) begin
      r_out_val <= 1'b0;
    end
  end

  assign bus.out_val     = r_out_val;
  assign bus.out_seq_num = r_msg.seq_num;
  assign bus.out_pc      = r_msg.pc;
  assign bus.out_waddr   = r_msg.waddr;
  assign bus.out_wdata   = r_msg.wdata;
  assign bus.out_wen     = r_msg.wen;
  assign bus.out_src     = r_src;

`ifdef BLIMP_WB_ARB_STATS_EN
  logic [p_num_pipes-1:0][CNT_W-1:0] r_grant_count;

  // Per-pipe transfer counters that stick at SATURATE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_grant_count <= '0;
    end else begin
      for (int unsigned i = 0; i < p_num_pipes; i++) begin
        if (w_xfer && w_grant[i] && (r_grant_count[i] != SATURATE)) begin
          r_grant_count[i] <= r_grant_count[i] + CNT_W'(1);
        end
      end
    end
  end

  assign grant_count = r_grant_count;
`endif

endmodule
